// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared score widths, FSM encoding and seven-segment digit patterns
package score_pkg;

    localparam int SCORE_W           = 7;
    localparam int SCORE_MAX_DEFAULT = 99;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PLAY       = 2'd1,
        ST_OVER_SCORE = 2'd2,
        ST_OVER_HIGH  = 2'd3
    } state_t;

    // Segment order gfedcba, active high; index 0 is digit 0
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] seg_digit(input logic [3:0] digit);
        return (digit <= 4'd9) ? SEG_DIGITS[digit] : 7'h00;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// rtl/dwell_timer.sv - per-phase dwell counter with registered blank window and expiry flag
module dwell_timer #(
    parameter int DWELL_CYCLES = 25_000_000,
    parameter int BLANK_CYCLES = 2_500_000
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Clear,
    input  logic i_Enable,
    output logic o_Blank_Window,
    output logic o_Expire
);

    localparam int TW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [TW-1:0] LAST      = TW'(DWELL_CYCLES - 1);
    localparam logic [TW-1:0] BLANK_END = TW'(BLANK_CYCLES);

    logic [TW-1:0] count_q, count_d;
    logic          window_q, window_d;

    // Clear starts a phase at count 0, enable advances it, neither parks the timer idle
    always_comb begin
        count_d  = '0;
        window_d = 1'b0;
        if (i_Clear) begin
            count_d  = '0;
            window_d = (BLANK_END != '0);
        end else if (i_Enable) begin
            count_d  = count_q + TW'(1);
            window_d = (count_d < BLANK_END);
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            count_q  <= '0;
            window_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            window_q <= window_d;
        end
    end

    assign o_Blank_Window = window_q;
    assign o_Expire       = (count_q == LAST);

endmodule

// File: rtl/score_scheduler.sv
// rtl/score_scheduler.sv - game score FSM: counts points, keeps high score, alternates final/high after game over
module score_scheduler
    import score_pkg::*;
#(
    parameter int DWELL_CYCLES = 25_000_000,
    parameter int BLANK_CYCLES = 2_500_000,
    parameter int SCORE_MAX    = SCORE_MAX_DEFAULT
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Start,
    input  logic       i_Point,
    input  logic       i_Game_Over,
    output logic [6:0] o_Score,
    output logic       o_Blank,
    output logic [6:0] o_High_Score,
    output logic       o_New_Record,
    output logic [1:0] o_State
);

    localparam logic [SCORE_W-1:0] SMAX = SCORE_W'(SCORE_MAX);

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] high_q, high_d;
    logic [SCORE_W-1:0] out_score_q, out_score_d;
    logic               rec_q, rec_d;
    logic [SCORE_W-1:0] score_inc, final_score;
    logic               tmr_clear, tmr_enable, tmr_expire, tmr_window;

    assign score_inc   = (score_q < SMAX) ? score_q + SCORE_W'(1) : score_q;
    assign final_score = i_Point ? score_inc : score_q;

    // score_q doubles as the final score once the game is over
    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        high_d     = high_q;
        rec_d      = rec_q;
        tmr_clear  = 1'b0;
        tmr_enable = 1'b0;
        if (i_Start) begin
            state_d = ST_PLAY;
            score_d = '0;
            rec_d   = 1'b0;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    if (i_Game_Over) begin
                        state_d   = ST_OVER_SCORE;
                        score_d   = final_score;
                        tmr_clear = 1'b1;
                        if (final_score > high_q) begin
                            high_d = final_score;
                            rec_d  = 1'b1;
                        end
                    end else if (i_Point) begin
                        score_d = score_inc;
                    end
                end
                ST_OVER_SCORE, ST_OVER_HIGH: begin
                    if (tmr_expire) begin
                        state_d   = (state_q == ST_OVER_SCORE) ? ST_OVER_HIGH : ST_OVER_SCORE;
                        tmr_clear = 1'b1;
                    end else begin
                        tmr_enable = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        out_score_d = score_d;
        if (state_d == ST_IDLE || state_d == ST_OVER_HIGH) begin
            out_score_d = high_d;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q     <= ST_IDLE;
            score_q     <= '0;
            high_q      <= '0;
            rec_q       <= 1'b0;
            out_score_q <= '0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            high_q      <= high_d;
            rec_q       <= rec_d;
            out_score_q <= out_score_d;
        end
    end

    dwell_timer #(
        .DWELL_CYCLES(DWELL_CYCLES),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_dwell_timer (
        .i_Clk         (i_Clk),
        .i_Rst_L       (i_Rst_L),
        .i_Clear       (tmr_clear),
        .i_Enable      (tmr_enable),
        .o_Blank_Window(tmr_window),
        .o_Expire      (tmr_expire)
    );

    assign o_Score      = out_score_q;
    assign o_Blank      = tmr_window;
    assign o_High_Score = high_q;
    assign o_New_Record = rec_q;
    assign o_State      = state_q;

endmodule

// File: tb/tb_score_scheduler.sv
// tb/tb_score_scheduler.sv - directed self-checking bench for score_scheduler
module tb_score_scheduler;

    logic       i_Clk = 1'b0;
    logic       i_Rst_L = 1'b0;
    logic       i_Start = 1'b0;
    logic       i_Point = 1'b0;
    logic       i_Game_Over = 1'b0;
    logic [6:0] o_Score;
    logic       o_Blank;
    logic [6:0] o_High_Score;
    logic       o_New_Record;
    logic [1:0] o_State;

    int checks = 0;
    int errors = 0;

    score_scheduler #(
        .DWELL_CYCLES(8),
        .BLANK_CYCLES(2),
        .SCORE_MAX   (99)
    ) dut (
        .i_Clk       (i_Clk),
        .i_Rst_L     (i_Rst_L),
        .i_Start     (i_Start),
        .i_Point     (i_Point),
        .i_Game_Over (i_Game_Over),
        .o_Score     (o_Score),
        .o_Blank     (o_Blank),
        .o_High_Score(o_High_Score),
        .o_New_Record(o_New_Record),
        .o_State     (o_State)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic tick(input int n);
        repeat (n) @(negedge i_Clk);
    endtask

    task automatic pulse(input logic s, input logic p, input logic g);
        i_Start = s; i_Point = p; i_Game_Over = g;
        @(negedge i_Clk);
        i_Start = 1'b0; i_Point = 1'b0; i_Game_Over = 1'b0;
    endtask

    task automatic test_reset();
        i_Rst_L = 1'b0;
        tick(2);
        checks++; if (o_State !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", o_State); end
        checks++; if (o_Score !== 7'd0) begin errors++; $display("FAIL reset_score got %0d exp 0", o_Score); end
        checks++; if (o_High_Score !== 7'd0) begin errors++; $display("FAIL reset_high got %0d exp 0", o_High_Score); end
        checks++; if (o_Blank !== 1'b0) begin errors++; $display("FAIL reset_blank got %0b exp 0", o_Blank); end
        checks++; if (o_New_Record !== 1'b0) begin errors++; $display("FAIL reset_rec got %0b exp 0", o_New_Record); end
        i_Rst_L = 1'b1;
        tick(1);
    endtask

    task automatic test_first_game();
        int nb, ns;
        pulse(1, 0, 0);
        checks++; if (o_State !== 2'd1) begin errors++; $display("FAIL g1_start_state got %0d exp 1", o_State); end
        repeat (5) pulse(0, 1, 0);
        checks++; if (o_Score !== 7'd5) begin errors++; $display("FAIL g1_play_score got %0d exp 5", o_Score); end
        pulse(0, 0, 1);
        checks++; if (o_State !== 2'd2) begin errors++; $display("FAIL g1_over_state got %0d exp 2", o_State); end
        checks++; if (o_Score !== 7'd5) begin errors++; $display("FAIL g1_over_score got %0d exp 5", o_Score); end
        checks++; if (o_High_Score !== 7'd5) begin errors++; $display("FAIL g1_high got %0d exp 5", o_High_Score); end
        checks++; if (o_New_Record !== 1'b1) begin errors++; $display("FAIL g1_rec got %0b exp 1", o_New_Record); end
        checks++; if (o_Blank !== 1'b1) begin errors++; $display("FAIL g1_blank_first got %0b exp 1", o_Blank); end
        nb = 0; ns = 0;
        for (int i = 0; i < 8; i++) begin
            if (o_Blank === 1'b1) nb++;
            if (o_State === 2'd2) ns++;
            if (i < 7) tick(1);
        end
        checks++; if (nb !== 2) begin errors++; $display("FAIL g1_score_phase_blanks got %0d exp 2", nb); end
        checks++; if (ns !== 8) begin errors++; $display("FAIL g1_score_phase_len got %0d exp 8", ns); end
        tick(1);
        checks++; if (o_State !== 2'd3) begin errors++; $display("FAIL g1_toggle_state got %0d exp 3", o_State); end
        checks++; if (o_Score !== 7'd5) begin errors++; $display("FAIL g1_toggle_score got %0d exp 5", o_Score); end
        nb = 0; ns = 0;
        for (int i = 0; i < 8; i++) begin
            if (o_Blank === 1'b1) nb++;
            if (o_State === 2'd3) ns++;
            if (i < 7) tick(1);
        end
        checks++; if (nb !== 2) begin errors++; $display("FAIL g1_high_phase_blanks got %0d exp 2", nb); end
        checks++; if (ns !== 8) begin errors++; $display("FAIL g1_high_phase_len got %0d exp 8", ns); end
        tick(1);
        checks++; if (o_State !== 2'd2) begin errors++; $display("FAIL g1_back_state got %0d exp 2", o_State); end
    endtask

    task automatic test_second_game();
        pulse(1, 0, 0);
        checks++; if (o_New_Record !== 1'b0) begin errors++; $display("FAIL g2_start_rec got %0b exp 0", o_New_Record); end
        repeat (3) pulse(0, 1, 0);
        pulse(0, 0, 1);
        checks++; if (o_Score !== 7'd3) begin errors++; $display("FAIL g2_over_score got %0d exp 3", o_Score); end
        checks++; if (o_High_Score !== 7'd5) begin errors++; $display("FAIL g2_high got %0d exp 5", o_High_Score); end
        checks++; if (o_New_Record !== 1'b0) begin errors++; $display("FAIL g2_rec got %0b exp 0", o_New_Record); end
        tick(8);
        checks++; if (o_Score !== 7'd5) begin errors++; $display("FAIL g2_alt1_score got %0d exp 5", o_Score); end
        tick(8);
        checks++; if (o_Score !== 7'd3) begin errors++; $display("FAIL g2_alt2_score got %0d exp 3", o_Score); end
        checks++; if (o_State !== 2'd2) begin errors++; $display("FAIL g2_alt2_state got %0d exp 2", o_State); end
        pulse(1, 0, 0);
        repeat (5) pulse(0, 1, 0);
        pulse(0, 0, 1);
        checks++; if (o_New_Record !== 1'b0) begin errors++; $display("FAIL g3_equal_rec got %0b exp 0", o_New_Record); end
        checks++; if (o_High_Score !== 7'd5) begin errors++; $display("FAIL g3_equal_high got %0d exp 5", o_High_Score); end
    endtask

    task automatic test_saturation();
        pulse(1, 0, 0);
        repeat (98) pulse(0, 1, 0);
        checks++; if (o_Score !== 7'd98) begin errors++; $display("FAIL sat_98 got %0d exp 98", o_Score); end
        pulse(0, 1, 0);
        checks++; if (o_Score !== 7'd99) begin errors++; $display("FAIL sat_99 got %0d exp 99", o_Score); end
        repeat (6) pulse(0, 1, 0);
        checks++; if (o_Score !== 7'd99) begin errors++; $display("FAIL sat_hold got %0d exp 99", o_Score); end
        pulse(0, 0, 1);
        checks++; if (o_High_Score !== 7'd99) begin errors++; $display("FAIL sat_high got %0d exp 99", o_High_Score); end
        checks++; if (o_New_Record !== 1'b1) begin errors++; $display("FAIL sat_rec got %0b exp 1", o_New_Record); end
    endtask

    task automatic test_coincident();
        pulse(1, 0, 0);
        repeat (4) pulse(0, 1, 0);
        pulse(0, 1, 1);
        checks++; if (o_State !== 2'd2) begin errors++; $display("FAIL co_go_state got %0d exp 2", o_State); end
        checks++; if (o_Score !== 7'd5) begin errors++; $display("FAIL co_go_score got %0d exp 5", o_Score); end
        pulse(1, 1, 0);
        checks++; if (o_State !== 2'd1) begin errors++; $display("FAIL co_start_state got %0d exp 1", o_State); end
        checks++; if (o_Score !== 7'd0) begin errors++; $display("FAIL co_start_score got %0d exp 0", o_Score); end
        pulse(0, 0, 1);
        tick(8);
        checks++; if (o_State !== 2'd3) begin errors++; $display("FAIL co_high_state got %0d exp 3", o_State); end
        checks++; if (o_Blank !== 1'b1) begin errors++; $display("FAIL co_high_blank got %0b exp 1", o_Blank); end
        pulse(1, 0, 0);
        checks++; if (o_State !== 2'd1) begin errors++; $display("FAIL co_restart_state got %0d exp 1", o_State); end
        checks++; if (o_Blank !== 1'b0) begin errors++; $display("FAIL co_restart_blank got %0b exp 0", o_Blank); end
        repeat (2) pulse(0, 1, 0);
        pulse(1, 0, 0);
        checks++; if (o_Score !== 7'd0) begin errors++; $display("FAIL co_play_restart got %0d exp 0", o_Score); end
    endtask

    task automatic test_idle_ignore();
        i_Rst_L = 1'b0;
        tick(1);
        i_Rst_L = 1'b1;
        tick(1);
        pulse(0, 1, 0);
        pulse(0, 0, 1);
        pulse(0, 1, 1);
        checks++; if (o_State !== 2'd0) begin errors++; $display("FAIL idle_state got %0d exp 0", o_State); end
        checks++; if (o_Score !== 7'd0) begin errors++; $display("FAIL idle_score got %0d exp 0", o_Score); end
        checks++; if (o_High_Score !== 7'd0) begin errors++; $display("FAIL idle_high got %0d exp 0", o_High_Score); end
    endtask

    task automatic test_async_reset();
        pulse(1, 0, 0);
        repeat (12) pulse(0, 1, 0);
        pulse(0, 0, 1);
        pulse(1, 0, 0);
        repeat (7) pulse(0, 1, 0);
        checks++; if (o_Score !== 7'd7) begin errors++; $display("FAIL ar_pre_score got %0d exp 7", o_Score); end
        checks++; if (o_High_Score !== 7'd12) begin errors++; $display("FAIL ar_pre_high got %0d exp 12", o_High_Score); end
        @(posedge i_Clk);
        #2 i_Rst_L = 1'b0;
        #1;
        checks++; if (o_Score !== 7'd0) begin errors++; $display("FAIL ar_score got %0d exp 0", o_Score); end
        checks++; if (o_High_Score !== 7'd0) begin errors++; $display("FAIL ar_high got %0d exp 0", o_High_Score); end
        checks++; if (o_State !== 2'd0) begin errors++; $display("FAIL ar_state got %0d exp 0", o_State); end
        checks++; if (o_New_Record !== 1'b0) begin errors++; $display("FAIL ar_rec got %0b exp 0", o_New_Record); end
        checks++; if (o_Blank !== 1'b0) begin errors++; $display("FAIL ar_blank got %0b exp 0", o_Blank); end
        @(negedge i_Clk);
        i_Rst_L = 1'b1;
        tick(1);
        checks++; if (o_State !== 2'd0) begin errors++; $display("FAIL ar_release_state got %0d exp 0", o_State); end
    endtask

    initial begin
        test_reset();
        test_first_game();
        test_second_game();
        test_saturation();
        test_coincident();
        test_idle_ignore();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
